// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw button inputs and conditioned strobe/level outputs
interface key_conditioner_if;
  logic [3:0] i_key_n;
  logic [3:0] o_press;
  logic [3:0] o_release;
  logic [3:0] o_step;
  logic [3:0] o_level;
  modport master (output i_key_n, input o_press, o_release, o_step, o_level);
  modport slave (input i_key_n, output o_press, o_release, o_step, o_level);
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and auto-repeat four active-low push buttons
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter logic [3:0] REPEAT_EN = 4'b1100
) (
  input logic CLOCK_50,
  input logic reset,
  key_conditioner_if.slave bus
);
  localparam int MAX_AB = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = MAX_AB > REPEAT_PERIOD ? MAX_AB : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_P) + 1;
  typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE} state_t;
  logic [3:0] r_s1, r_ks;
  // two-flop synchroniser; only r_s1 sees the raw buttons, reset reads as released
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_s1 <= '0;
      r_ks <= '0;
    end else begin
      r_s1 <= ~bus.i_key_n;
      r_ks <= r_s1;
    end
  end
  for (genvar k = 0; k < 4; k++) begin : g_key
    state_t r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic r_press, r_release, r_step;
    logic w_press, w_release, w_step;
    // per-key debounce / repeat next-state; counter saturates instead of wrapping
    always_comb begin
      w_state = r_state;
      w_cnt = &r_cnt ? r_cnt : r_cnt + 1'b1;
      w_press = 1'b0;
      w_release = 1'b0;
      w_step = 1'b0;
      case (r_state)
        IDLE: begin
          w_cnt = '0;
          if (r_ks[k]) w_state = DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!r_ks[k]) begin
            w_state = IDLE;
            w_cnt = '0;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            w_state = HELD;
            w_cnt = '0;
            w_press = 1'b1;
            w_step = 1'b1;
          end
        end
        HELD: begin
          if (!r_ks[k]) begin
            w_state = DEB_RELEASE;
            w_cnt = '0;
          end else if (REPEAT_EN[k] && r_cnt == CW'(REPEAT_DELAY - 1)) begin
            w_state = REPEAT;
            w_cnt = '0;
            w_step = 1'b1;
          end
        end
        REPEAT: begin
          if (!r_ks[k]) begin
            w_state = DEB_RELEASE;
            w_cnt = '0;
          end else if (r_cnt == CW'(REPEAT_PERIOD - 1)) begin
            w_cnt = '0;
            w_step = 1'b1;
          end
        end
        DEB_RELEASE: begin
          if (r_ks[k]) begin
            w_state = HELD;
            w_cnt = '0;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            w_state = IDLE;
            w_cnt = '0;
            w_release = 1'b1;
          end
        end
        default: begin
          w_state = IDLE;
          w_cnt = '0;
        end
      endcase
    end
    // state, counter and one-cycle strobe registers
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_state <= IDLE;
        r_cnt <= '0;
        r_press <= 1'b0;
        r_release <= 1'b0;
        r_step <= 1'b0;
      end else begin
        r_state <= w_state;
        r_cnt <= w_cnt;
        r_press <= w_press;
        r_release <= w_release;
        r_step <= w_step;
      end
    end
    assign bus.o_press[k] = r_press;
    assign bus.o_release[k] = r_release;
    assign bus.o_step[k] = r_step;
    assign bus.o_level[k] = r_state inside {HELD, REPEAT, DEB_RELEASE};
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed edge-by-edge checks of debounce, repeat and reset behaviour
module tb_key_conditioner;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  key_conditioner_if bus();
  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3),
    .REPEAT_EN(4'b1100)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic cyc(input string tag, input int k, input logic [3:0] p, input logic [3:0] r,
                     input logic [3:0] s, input logic [3:0] l);
    @(posedge CLOCK_50);
    #1;
    chk($sformatf("%s.press@%0d", tag, k), bus.o_press, p);
    chk($sformatf("%s.release@%0d", tag, k), bus.o_release, r);
    chk($sformatf("%s.step@%0d", tag, k), bus.o_step, s);
    chk($sformatf("%s.level@%0d", tag, k), bus.o_level, l);
  endtask
  initial begin
    bus.i_key_n = 4'hF;
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) cyc("reset", k, 4'b0, 4'b0, 4'b0, 4'b0);
    reset = 1'b0;
    bus.i_key_n[0] = 1'b0;
    for (int k = 1; k <= 20; k++)
      cyc("clean", k, {3'b0, k == 7}, 4'b0, {3'b0, k == 7}, {3'b0, k >= 7});
    bus.i_key_n[0] = 1'b1;
    for (int k = 1; k <= 10; k++)
      cyc("clean_rel", k, 4'b0, {3'b0, k == 7}, 4'b0, {3'b0, k < 7});
    for (int k = 1; k <= 12; k++) begin
      bus.i_key_n[1] = ((k - 1) / 2) % 2 == 1;
      cyc("bounce", k, 4'b0, 4'b0, 4'b0, 4'b0);
    end
    bus.i_key_n[1] = 1'b1;
    for (int k = 1; k <= 6; k++) cyc("bounce_tail", k, 4'b0, 4'b0, 4'b0, 4'b0);
    bus.i_key_n[2] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc("repeat", k, {1'b0, k == 7, 2'b0}, {1'b0, k == 36, 2'b0},
          {1'b0, k inside {7, 17, 20, 23, 26, 29}, 2'b0}, {1'b0, k >= 7 && k < 36, 2'b0});
      if (k == 29) bus.i_key_n[2] = 1'b1;
    end
    for (int k = 1; k <= 24; k++) begin
      bus.i_key_n[3] = !(k <= 8 || k == 11);
      cyc("rel_bounce", k, {k == 7, 3'b0}, {k == 18, 3'b0}, {k == 7, 3'b0},
          {k >= 7 && k < 18, 3'b0});
    end
    bus.i_key_n = 4'b1010;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) bus.i_key_n = 4'hF;
      cyc("simul", k, k == 7 ? 4'b0101 : 4'b0, k == 17 ? 4'b0101 : 4'b0,
          k == 7 ? 4'b0101 : 4'b0, (k >= 7 && k < 17) ? 4'b0101 : 4'b0);
    end
    bus.i_key_n[2] = 1'b0;
    for (int k = 1; k <= 19; k++)
      cyc("rst_pre", k, {1'b0, k == 7, 2'b0}, 4'b0, {1'b0, k inside {7, 17}, 2'b0},
          {1'b0, k >= 7, 2'b0});
    reset = 1'b1;
    cyc("rst_hold", 20, 4'b0, 4'b0, 4'b0, 4'b0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++)
      cyc("rst_after", k, {1'b0, k == 7, 2'b0}, 4'b0, {1'b0, k == 7, 2'b0}, {1'b0, k >= 7, 2'b0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
